// File: rtl/tpu_pkg.sv
// Shared types for the TPU host-side instruction path.
package tpu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] length;
    logic [23:0] buffer_addr;
    logic [15:0] acc_addr;
  } instr_type;

  localparam instr_type INIT_INSTR = '0;

  // Opcode that makes the issuer wait for the core's synchronize report
  localparam logic [7:0] SYNCHRONIZE_OPCODE = 8'hFF;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_SYNC = 1'b1
  } issuer_state_t;

endpackage

// File: rtl/tpu_instr_fifo.sv
// Synchronous FIFO of instructions: registered storage, combinational head.
module tpu_instr_fifo
  import tpu_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  instr_type  wdata,
  input  logic       pop,
  output instr_type  rdata,
  output logic       empty,
  output logic       full,
  output logic [AW:0] count
);

  instr_type   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO never accepts, even if it pops on the same edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tpu_instr_issuer.sv
// Host-side issuer: buffers host instructions and feeds tpu_core one per
// cycle while it is idle, stalling after a synchronize until the core reports it.
module tpu_instr_issuer
  import tpu_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 32,
  parameter logic [7:0] SYNC_OPCODE = SYNCHRONIZE_OPCODE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  instr_type                   host_instr,
  input  logic                        host_valid,
  output logic                        host_ready,
  output instr_type                   core_instr_port,
  output logic                        core_instr_enable,
  input  logic                        core_busy,
  input  logic                        core_synchronize,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        sync_pending,
  output logic                        sync_done,
  output logic                        drop_error
);

  issuer_state_t state_q, state_d;
  instr_type     port_q, port_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          pop, empty, full;
  instr_type     head;

  tpu_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (host_valid),
    .wdata (host_instr),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (fifo_count)
  );

  assign host_ready        = !full;
  assign core_instr_port   = port_q;
  assign core_instr_enable = en_q;
  assign sync_pending      = (state_q == ST_WAIT_SYNC);
  assign sync_done         = done_q;
  assign drop_error        = drop_q;

  // Issue decision, sync stall FSM and sticky drop flag
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    drop_d  = drop_q | (host_valid & full);
    case (state_q)
      ST_IDLE: begin
        if (enable && !core_busy && !empty) begin
          pop    = 1'b1;
          en_d   = 1'b1;
          port_d = head;
          if (head.opcode == SYNC_OPCODE) state_d = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        // Completes regardless of enable
        if (core_synchronize) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      port_q  <= INIT_INSTR;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      en_q    <= en_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_tpu_instr_issuer.sv
// Directed bench for tpu_instr_issuer: reset, burst, sync stall, busy, full FIFO, enable toggle.
module tb_tpu_instr_issuer;
  import tpu_pkg::*;

  logic      clk = 1'b0;
  logic      rst, enable, host_valid, host_ready;
  logic      core_instr_enable, core_busy, core_synchronize;
  logic      sync_pending, sync_done, drop_error;
  instr_type host_instr, core_instr_port;
  logic [5:0] fifo_count;

  int errors = 0;
  int checks = 0;

  tpu_instr_issuer #(.FIFO_DEPTH(32), .SYNC_OPCODE(8'hFF)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .host_instr        (host_instr),
    .host_valid        (host_valid),
    .host_ready        (host_ready),
    .core_instr_port   (core_instr_port),
    .core_instr_enable (core_instr_enable),
    .core_busy         (core_busy),
    .core_synchronize  (core_synchronize),
    .fifo_count        (fifo_count),
    .sync_pending      (sync_pending),
    .sync_done         (sync_done),
    .drop_error        (drop_error)
  );

  always #5 clk = ~clk;

  function automatic instr_type mk(input logic [7:0] op, input logic [31:0] len);
    instr_type t;
    t.opcode      = op;
    t.length      = len;
    t.buffer_addr = {16'h00B0, op};
    t.acc_addr    = {8'h0A, op};
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // get into WAIT_SYNC with three words buffered
    enable = 1'b1;
    host_valid = 1'b1; host_instr = mk(8'hFF, 32'd0);
    tick();
    host_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1; host_instr = mk(8'h10 + 8'(i), 32'd5);
      tick();
    end
    host_valid = 1'b0;
    checks++; if (fifo_count !== 6'd3 || sync_pending !== 1'b1) begin
      errors++; $display("FAIL pre_reset: count=%0d pending=%b want 3/1", fifo_count, sync_pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fifo_count !== 6'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    checks++; if (core_instr_enable !== 1'b0 || core_instr_port !== INIT_INSTR) begin
      errors++; $display("FAIL reset_port: en=%b port=%h want 0/%h", core_instr_enable, core_instr_port, INIT_INSTR);
    end
    checks++; if ({sync_pending, sync_done, drop_error, host_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_flags: pend/done/drop/ready=%b want 0001",
                         {sync_pending, sync_done, drop_error, host_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (core_instr_enable !== 1'b0) begin
        errors++; $display("FAIL reset_no_reissue: en=%b want 0 at cycle %0d", core_instr_enable, i);
      end
    end
  endtask

  task automatic test_burst();
    instr_type v [4];
    v[0] = mk(8'h09, 32'd14); v[1] = mk(8'h21, 32'd14);
    v[2] = mk(8'h99, 32'd14); v[3] = mk(8'hFF, 32'd0);
    enable = 1'b1; core_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_valid = (i < 4);
      if (i < 4) host_instr = v[i];
      tick();
      if (i == 0) begin
        checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd1) begin
          errors++; $display("FAIL burst_latency: en=%b count=%0d want 0/1", core_instr_enable, fifo_count);
        end
      end else begin
        checks++; if (core_instr_enable !== 1'b1 || core_instr_port !== v[i-1]) begin
          errors++; $display("FAIL burst_issue%0d: en=%b port=%h want 1/%h", i-1, core_instr_enable, core_instr_port, v[i-1]);
        end
        checks++; if (fifo_count !== ((i == 4) ? 6'd0 : 6'd1)) begin
          errors++; $display("FAIL burst_count%0d: got %0d", i, fifo_count);
        end
      end
    end
    checks++; if (sync_pending !== 1'b1) begin
      errors++; $display("FAIL burst_sync_pending: got %b want 1", sync_pending);
    end
    tick();
    checks++; if (core_instr_enable !== 1'b0 || sync_pending !== 1'b1) begin
      errors++; $display("FAIL burst_stall: en=%b pend=%b want 0/1", core_instr_enable, sync_pending);
    end
  endtask

  task automatic test_sync_release();
    host_valid = 1'b1; host_instr = mk(8'h09, 32'd14);
    tick();
    host_valid = 1'b0;
    checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd1 || sync_pending !== 1'b1) begin
      errors++; $display("FAIL sync_hold: en=%b count=%0d pend=%b want 0/1/1", core_instr_enable, fifo_count, sync_pending);
    end
    tick();
    checks++; if (core_instr_enable !== 1'b0) begin
      errors++; $display("FAIL sync_hold2: en=%b want 0", core_instr_enable);
    end
    core_synchronize = 1'b1;
    tick();
    core_synchronize = 1'b0;
    checks++; if (sync_done !== 1'b1 || sync_pending !== 1'b0 || core_instr_enable !== 1'b0) begin
      errors++; $display("FAIL sync_done: done=%b pend=%b en=%b want 1/0/0", sync_done, sync_pending, core_instr_enable);
    end
    tick();
    checks++; if (core_instr_enable !== 1'b1 || core_instr_port.opcode !== 8'h09 || sync_done !== 1'b0) begin
      errors++; $display("FAIL sync_resume: en=%b op=%h done=%b want 1/09/0", core_instr_enable, core_instr_port.opcode, sync_done);
    end
    tick();
    checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd0) begin
      errors++; $display("FAIL sync_after: en=%b count=%0d want 0/0", core_instr_enable, fifo_count);
    end
  endtask

  task automatic test_busy();
    core_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      host_valid = 1'b1; host_instr = mk(8'h30 + 8'(i), 32'd7 + 32'(i));
      tick();
    end
    host_valid = 1'b0;
    tick();
    checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd2) begin
      errors++; $display("FAIL busy_block: en=%b count=%0d want 0/2", core_instr_enable, fifo_count);
    end
    core_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (core_instr_enable !== 1'b1 || core_instr_port !== mk(8'h30 + 8'(i), 32'd7 + 32'(i))) begin
        errors++; $display("FAIL busy_release%0d: en=%b port=%h", i, core_instr_enable, core_instr_port);
      end
    end
    tick();
    checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd0) begin
      errors++; $display("FAIL busy_drain: en=%b count=%0d want 0/0", core_instr_enable, fifo_count);
    end
  endtask

  task automatic test_full_wrap();
    enable = 1'b0;
    for (int i = 0; i < 33; i++) begin
      host_valid = 1'b1; host_instr = mk(8'h40 + 8'(i), 32'(i * 3));
      tick();
      checks++; if (fifo_count !== 6'((i < 32) ? i + 1 : 32) || host_ready !== (i < 31) ||
                    drop_error !== (i == 32)) begin
        errors++; $display("FAIL full_fill%0d: count=%0d ready=%b drop=%b", i, fifo_count, host_ready, drop_error);
      end
    end
    host_valid = 1'b0;
    enable = 1'b1;
    for (int j = 0; j < 32; j++) begin
      tick();
      checks++; if (core_instr_enable !== 1'b1 || core_instr_port !== mk(8'h40 + 8'(j), 32'(j * 3))) begin
        errors++; $display("FAIL full_drain%0d: en=%b port=%h want %h", j, core_instr_enable, core_instr_port,
                           mk(8'h40 + 8'(j), 32'(j * 3)));
      end
    end
    tick();
    checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd0 || host_ready !== 1'b1 || drop_error !== 1'b1) begin
      errors++; $display("FAIL full_end: en=%b count=%0d ready=%b drop=%b want 0/0/1/1",
                         core_instr_enable, fifo_count, host_ready, drop_error);
    end
  endtask

  task automatic test_idle_sync_enable();
    core_synchronize = 1'b1;
    tick();
    core_synchronize = 1'b0;
    checks++; if (sync_done !== 1'b0 || sync_pending !== 1'b0) begin
      errors++; $display("FAIL idle_sync: done=%b pend=%b want 0/0", sync_done, sync_pending);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_instr = mk(8'hC0 + 8'(i), 32'd100 + 32'(i));
      tick();
    end
    host_valid = 1'b0;
    enable = 1'b1;
    tick();
    checks++; if (core_instr_enable !== 1'b1 || core_instr_port !== mk(8'hC0, 32'd100)) begin
      errors++; $display("FAIL en_c0: en=%b port=%h", core_instr_enable, core_instr_port);
    end
    // busy rising while the instruction is presented only blocks the next one
    core_busy = 1'b1;
    tick();
    core_busy = 1'b0;
    checks++; if (core_instr_enable !== 1'b0 || core_instr_port !== mk(8'hC0, 32'd100)) begin
      errors++; $display("FAIL busy_hold: en=%b port=%h", core_instr_enable, core_instr_port);
    end
    tick();
    checks++; if (core_instr_enable !== 1'b1 || core_instr_port !== mk(8'hC1, 32'd101)) begin
      errors++; $display("FAIL en_c1: en=%b port=%h", core_instr_enable, core_instr_port);
    end
    enable = 1'b0;
    tick();
    tick();
    checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd2) begin
      errors++; $display("FAIL en_pause: en=%b count=%0d want 0/2", core_instr_enable, fifo_count);
    end
    enable = 1'b1;
    for (int i = 2; i < 4; i++) begin
      tick();
      checks++; if (core_instr_enable !== 1'b1 || core_instr_port !== mk(8'hC0 + 8'(i), 32'd100 + 32'(i))) begin
        errors++; $display("FAIL en_resume%0d: en=%b port=%h", i, core_instr_enable, core_instr_port);
      end
    end
    tick();
    checks++; if (core_instr_enable !== 1'b0 || fifo_count !== 6'd0) begin
      errors++; $display("FAIL en_end: en=%b count=%0d want 0/0", core_instr_enable, fifo_count);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; host_valid = 1'b0; host_instr = INIT_INSTR;
    core_busy = 1'b0; core_synchronize = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_burst();
    test_sync_release();
    test_busy();
    test_full_wrap();
    test_idle_sync_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
